// File: rtl/pa_hpcp_cnt_ctrl_if.sv
// Event, CSR and status bundle between the pipeline/CSR unit (master) and the
// performance-counter controller (slave).
interface pa_hpcp_cnt_ctrl_if #(
    parameter int CNT_NUM = 4,
    parameter int EVT_NUM = 32
);
    logic [EVT_NUM-1:0]   hpcp_evt_vld;
    logic [5*CNT_NUM-1:0] hpcp_evt_sel;
    logic [CNT_NUM-1:0]   hpcp_inhibit;
    logic                 hpcp_csr_wen;
    logic [2:0]           hpcp_csr_idx;
    logic                 hpcp_csr_hi;
    logic [31:0]          hpcp_wdata;
    logic [31:0]          hpcp_rdata;
    logic [CNT_NUM-1:0]   hpcp_ovf;
    logic [CNT_NUM-1:0]   cnt_clk_en;

    modport master (
        output hpcp_evt_vld, hpcp_evt_sel, hpcp_inhibit,
        output hpcp_csr_wen, hpcp_csr_idx, hpcp_csr_hi, hpcp_wdata,
        input  hpcp_rdata, hpcp_ovf, cnt_clk_en
    );

    modport slave (
        input  hpcp_evt_vld, hpcp_evt_sel, hpcp_inhibit,
        input  hpcp_csr_wen, hpcp_csr_idx, hpcp_csr_hi, hpcp_wdata,
        output hpcp_rdata, hpcp_ovf, cnt_clk_en
    );
endinterface

// File: rtl/pa_hpcp_cnt_ctrl.sv
// PMU hardware performance counters: 2-stage sample/update of event pulses,
// CSR word writes with priority over increments, sticky overflow, clock-enable requests.
module pa_hpcp_cnt_lane #(
    parameter int EVT_NUM = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [EVT_NUM-1:0] evt_q,
    input  logic [4:0]         sel,
    input  logic               inhibit,
    input  logic               hit,
    input  logic               hi,
    input  logic [31:0]        wdata,
    output logic [63:0]        cnt,
    output logic               ovf,
    output logic               upd
);
    logic [63:0] cnt_d, cnt_q;
    logic        ovf_d, ovf_q;
    logic        inc;

    assign inc = evt_q[sel] & (sel != 5'd0) & ~inhibit;
    assign upd = hit | inc;

    // A write wins outright; the colliding event is dropped, not deferred.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (hit) begin
            if (hi) cnt_d[63:32] = wdata;
            else    cnt_d[31:0]  = wdata;
            ovf_d = 1'b0;
        end else if (inc) begin
            cnt_d = cnt_q + 64'd1;
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (upd) begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

module pa_hpcp_cnt_ctrl #(
    parameter int CNT_NUM = 4,
    parameter int EVT_NUM = 32
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic                pad_yy_icg_scan_en,
    input  logic                cp0_hpcp_icg_en,
    pa_hpcp_cnt_ctrl_if.slave   bus
);
    typedef struct packed {
        logic        wen;
        logic [2:0]  idx;
        logic        hi;
        logic [31:0] wdata;
    } wr_t;

    logic [EVT_NUM-1:0]      evt_d, evt_q;
    wr_t                     wr_d, wr_q;
    logic [CNT_NUM-1:0][63:0] cnt;
    logic [CNT_NUM-1:0]      ovf;
    logic [CNT_NUM-1:0]      upd;
    logic [31:0]             rdata;

    // Stage 1: line 0 is reserved as the "no event" selector, so never sample it.
    always_comb begin
        evt_d       = {bus.hpcp_evt_vld[EVT_NUM-1:1], 1'b0};
        wr_d.wen    = bus.hpcp_csr_wen;
        wr_d.idx    = bus.hpcp_csr_idx;
        wr_d.hi     = bus.hpcp_csr_hi;
        wr_d.wdata  = bus.hpcp_wdata;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            evt_q <= '0;
            wr_q  <= '0;
        end else begin
            evt_q <= evt_d;
            wr_q  <= wr_d;
        end
    end

    // Stage 2: selector and inhibit are taken live, not from stage 1.
    for (genvar i = 0; i < CNT_NUM; i++) begin : g_lane
        pa_hpcp_cnt_lane #(.EVT_NUM(EVT_NUM)) u_lane (
            .clk     (forever_cpuclk),
            .rst_n   (cpurst_b),
            .evt_q   (evt_q),
            .sel     (bus.hpcp_evt_sel[5*i +: 5]),
            .inhibit (bus.hpcp_inhibit[i]),
            .hit     (wr_q.wen & (wr_q.idx == 3'(i))),
            .hi      (wr_q.hi),
            .wdata   (wr_q.wdata),
            .cnt     (cnt[i]),
            .ovf     (ovf[i]),
            .upd     (upd[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CNT_NUM; i++) begin
            if (bus.hpcp_csr_idx == 3'(i))
                rdata = bus.hpcp_csr_hi ? cnt[i][63:32] : cnt[i][31:0];
        end
    end

    assign bus.hpcp_rdata = rdata;
    assign bus.hpcp_ovf   = ovf;
    assign bus.cnt_clk_en = upd | {CNT_NUM{~cp0_hpcp_icg_en | pad_yy_icg_scan_en}};
endmodule

// File: tb/tb_pa_hpcp_cnt_ctrl.sv
// Bench for pa_hpcp_cnt_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a 64-bit counter model.
module tb_pa_hpcp_cnt_ctrl;
    localparam int CNT = 4;
    localparam int EVN = 32;

    logic clk = 1'b0;
    logic cpurst_b;
    logic scan_en;
    logic icg_en;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    pa_hpcp_cnt_ctrl_if #(.CNT_NUM(CNT), .EVT_NUM(EVN)) bus ();

    pa_hpcp_cnt_ctrl #(.CNT_NUM(CNT), .EVT_NUM(EVN)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (cpurst_b),
        .pad_yy_icg_scan_en (scan_en),
        .cp0_hpcp_icg_en    (icg_en),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    // Reference: each counter is a plain 64-bit integer; events and writes
    // presented in one cycle are applied at the following clock edge.
    logic [63:0]    m_cnt [CNT];
    logic [CNT-1:0] m_ovf;
    logic [EVN-1:0] m_evt;
    logic           m_wen;
    logic [2:0]     m_widx;
    logic           m_whi;
    logic [31:0]    m_wdata;

    function automatic logic m_inc(int i);
        logic [4:0] s;
        s = bus.hpcp_evt_sel[5*i +: 5];
        return (s != 5'd0) && m_evt[s] && !bus.hpcp_inhibit[i];
    endfunction

    function automatic logic m_hit(int i);
        return m_wen && (int'(m_widx) == i);
    endfunction

    always @(posedge clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < CNT; i++) m_cnt[i] = 64'd0;
            m_ovf = '0; m_evt = '0; m_wen = 1'b0; m_widx = '0; m_whi = 1'b0; m_wdata = '0;
        end else begin
            for (int i = 0; i < CNT; i++) begin
                if (m_hit(i)) begin
                    if (m_whi) m_cnt[i] = {m_wdata, m_cnt[i][31:0]};
                    else       m_cnt[i] = {m_cnt[i][63:32], m_wdata};
                    m_ovf[i] = 1'b0;
                end else if (m_inc(i)) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] + 64'd1;
                end
            end
            m_evt    = bus.hpcp_evt_vld;
            m_evt[0] = 1'b0;
            m_wen    = bus.hpcp_csr_wen;
            m_widx   = bus.hpcp_csr_idx;
            m_whi    = bus.hpcp_csr_hi;
            m_wdata  = bus.hpcp_wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0]    exp_rd;
            logic [CNT-1:0] exp_en;
            exp_rd = 32'd0;
            if (int'(bus.hpcp_csr_idx) < CNT)
                exp_rd = bus.hpcp_csr_hi ? m_cnt[bus.hpcp_csr_idx][63:32]
                                         : m_cnt[bus.hpcp_csr_idx][31:0];
            for (int i = 0; i < CNT; i++)
                exp_en[i] = m_hit(i) || m_inc(i) || !icg_en || scan_en;
            chk("model_rdata", 64'(bus.hpcp_rdata), 64'(exp_rd));
            chk("model_ovf", 64'(bus.hpcp_ovf), 64'(m_ovf));
            chk("model_clk_en", 64'(bus.cnt_clk_en), 64'(exp_en));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_sel(input int i, input logic [4:0] v);
        bus.hpcp_evt_sel[5*i +: 5] = v;
    endtask

    task automatic wr(input int idx, input logic hi, input logic [31:0] d);
        bus.hpcp_csr_wen = 1'b1; bus.hpcp_csr_idx = 3'(idx);
        bus.hpcp_csr_hi = hi; bus.hpcp_wdata = d;
        cyc();
        bus.hpcp_csr_wen = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int idx, input logic hi, input logic [31:0] exp);
        bus.hpcp_csr_idx = 3'(idx); bus.hpcp_csr_hi = hi;
        @(negedge clk);
        chk(nm, 64'(bus.hpcp_rdata), 64'(exp));
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        cpurst_b = 1'b0; scan_en = 1'b0; icg_en = 1'b1;
        bus.hpcp_evt_vld = '0; bus.hpcp_evt_sel = '0; bus.hpcp_inhibit = '0;
        bus.hpcp_csr_wen = 1'b0; bus.hpcp_csr_idx = '0; bus.hpcp_csr_hi = 1'b0;
        bus.hpcp_wdata = '0;
        idle(3);
        cpurst_b = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Reset state across all indices, including out-of-range ones.
        for (int i = 0; i < 8; i++) begin
            rd_chk("rst_lo", i, 1'b0, 32'd0);
            rd_chk("rst_hi", i, 1'b1, 32'd0);
        end
        @(negedge clk);
        chk("rst_ovf", 64'(bus.hpcp_ovf), 64'd0);
        chk("rst_clk_en", 64'(bus.cnt_clk_en), 64'd0);
        cyc();

        // Ten pulses on line 3 into counter 0.
        set_sel(0, 5'd3);
        bus.hpcp_evt_vld[3] = 1'b1;
        idle(10);
        bus.hpcp_evt_vld[3] = 1'b0;
        idle(1);
        rd_chk("evt10", 0, 1'b0, 32'd10);
        set_sel(0, 5'd0);
        bus.hpcp_evt_vld[0] = 1'b1;
        idle(4);
        bus.hpcp_evt_vld[0] = 1'b0;
        idle(2);
        rd_chk("bit0_ignored", 0, 1'b0, 32'd10);

        // Wrap of counter 1 from all-ones sets ovf; a write clears it.
        set_sel(1, 5'd5);
        wr(1, 1'b0, 32'hFFFF_FFFF);
        wr(1, 1'b1, 32'hFFFF_FFFF);
        idle(1);
        rd_chk("sat_hi", 1, 1'b1, 32'hFFFF_FFFF);
        bus.hpcp_evt_vld[5] = 1'b1;
        cyc();
        bus.hpcp_evt_vld[5] = 1'b0;
        idle(1);
        rd_chk("wrap_lo", 1, 1'b0, 32'd0);
        rd_chk("wrap_hi", 1, 1'b1, 32'd0);
        @(negedge clk);
        chk("ovf_set", 64'(bus.hpcp_ovf[1]), 64'd1);
        cyc();
        wr(1, 1'b0, 32'd0);
        idle(1);
        @(negedge clk);
        chk("ovf_clr", 64'(bus.hpcp_ovf[1]), 64'd0);
        cyc();

        // Write and increment collide on counter 2: the write wins.
        set_sel(2, 5'd7);
        bus.hpcp_evt_vld[7] = 1'b1;
        wr(2, 1'b0, 32'h5);
        bus.hpcp_evt_vld[7] = 1'b0;
        idle(1);
        rd_chk("wr_vs_inc_lo", 2, 1'b0, 32'h5);
        rd_chk("wr_vs_inc_hi", 2, 1'b1, 32'h0);

        // Inhibit counter 3 for four events, then count two.
        set_sel(3, 5'd9);
        bus.hpcp_inhibit[3] = 1'b1;
        bus.hpcp_evt_vld[9] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus.hpcp_evt_vld[9] = 1'b0;
            @(negedge clk);
            chk("inhibit_clk_en", 64'(bus.cnt_clk_en[3]), 64'd0);
            cyc();
        end
        bus.hpcp_inhibit[3] = 1'b0;
        bus.hpcp_evt_vld[9] = 1'b1;
        idle(2);
        bus.hpcp_evt_vld[9] = 1'b0;
        idle(1);
        rd_chk("inhibit_adv", 3, 1'b0, 32'd2);

        // Set ovf again, then reset asynchronously mid-count.
        wr(1, 1'b0, 32'hFFFF_FFFF);
        wr(1, 1'b1, 32'hFFFF_FFFF);
        bus.hpcp_evt_vld[5] = 1'b1;
        cyc();
        bus.hpcp_evt_vld = '1;
        idle(2);
        @(negedge clk);
        chk("ovf_before_rst", 64'(bus.hpcp_ovf[1]), 64'd1);
        cyc();
        bus.hpcp_csr_idx = 3'd0; bus.hpcp_csr_hi = 1'b0;
        #2 cpurst_b = 1'b0;
        #1;
        chk("async_rst_rd", 64'(bus.hpcp_rdata), 64'd0);
        chk("async_rst_ovf", 64'(bus.hpcp_ovf), 64'd0);
        cyc();
        for (int i = 0; i < CNT; i++) rd_chk("in_rst_rd", i, 1'b0, 32'd0);
        #2 cpurst_b = 1'b1;
        bus.hpcp_evt_vld = '0;
        cyc();
        bus.hpcp_evt_vld[3] = 1'b1;
        set_sel(0, 5'd3);
        idle(3);
        bus.hpcp_evt_vld[3] = 1'b0;
        idle(1);
        rd_chk("resume", 0, 1'b0, 32'd3);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            bus.hpcp_evt_vld = $urandom;
            if ($urandom_range(0, 15) == 0) bus.hpcp_evt_sel = 20'($urandom);
            if ($urandom_range(0, 7) == 0)  bus.hpcp_inhibit = 4'($urandom);
            icg_en  = ($urandom_range(0, 7) != 0);
            scan_en = ($urandom_range(0, 15) == 0);
            bus.hpcp_csr_wen = ($urandom_range(0, 3) == 0);
            bus.hpcp_csr_idx = 3'($urandom_range(0, 7));
            bus.hpcp_csr_hi  = 1'($urandom);
            bus.hpcp_wdata   = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
            if (c == 300) begin
                #2 cpurst_b = 1'b0;
                cyc();
                #2 cpurst_b = 1'b1;
            end
            cyc();
        end
        bus.hpcp_csr_wen = 1'b0;
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
